// File: rtl/rmw_pkg.sv
// Shared types for the read-modify-write RAM controller: operation codes and FSM states.
package rmw_pkg;

  typedef enum logic [1:0] {
    OP_REPLACE = 2'd0,
    OP_ADD     = 2'd1,
    OP_OR      = 2'd2,
    OP_AND     = 2'd3
  } rmw_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } rmw_state_e;

endpackage

// File: rtl/rmw_lane_alu.sv
// Single-lane fetch-and-op ALU. Define RMW_SATURATE_EN to clamp ADD at the lane maximum
// instead of wrapping.
module rmw_lane_alu
  import rmw_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] operand_i,
  input  rmw_op_e          op_i,
  output logic [WIDTH-1:0] result_o
);

`ifdef RMW_SATURATE_EN
  logic [WIDTH:0] sum;
  assign sum = {1'b0, old_i} + {1'b0, operand_i};
`else
  logic [WIDTH-1:0] sum;
  assign sum = old_i + operand_i;
`endif

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result_o unassigned (no latch).
    result_o = operand_i;
    case (op_i)
      OP_REPLACE: result_o = operand_i;
`ifdef RMW_SATURATE_EN
      OP_ADD:     result_o = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
      OP_ADD:     result_o = sum;
`endif
      OP_OR:      result_o = old_i | operand_i;
      OP_AND:     result_o = old_i & operand_i;
      default:    result_o = operand_i;
    endcase
  end

endmodule

// File: rtl/tdp_ram_rmw_ctrl.sv
// Fetch-and-op controller on one port of a read-first true-dual-port RAM: READ, WRITE, RESP.
// Optional macro RMW_SATURATE_EN selects saturating per-lane ADD (see rmw_lane_alu).
module tdp_ram_rmw_ctrl
  import rmw_pkg::*;
#(
  parameter  int MEM_WIDTH          = 16,
  parameter  int WRITE_STROBE_WIDTH = 4,
  parameter  int ADDR_WIDTH         = 8,
  localparam int LANES              = MEM_WIDTH / WRITE_STROBE_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [MEM_WIDTH-1:0]  s_data,
  input  logic [LANES-1:0]      s_mask,
  input  logic [1:0]            s_op,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [MEM_WIDTH-1:0]  m_data,
  output logic [ADDR_WIDTH-1:0] ramWriteAddr,
  output logic                  ramWrite,
  output logic [LANES-1:0]      ramWriteMask,
  output logic [MEM_WIDTH-1:0]  ramWriteData,
  input  logic [MEM_WIDTH-1:0]  ramWriteDataOut
);

  rmw_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [MEM_WIDTH-1:0]  data_q;
  logic [LANES-1:0]      mask_q;
  rmw_op_e               op_q;
  logic                  m_valid_q;
  logic [MEM_WIDTH-1:0]  m_data_q;
  logic [MEM_WIDTH-1:0]  result;
  logic                  accept;

  // Reset gates the handshake and the write strobe immediately, not only at the next edge.
  assign s_ready = resetn & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & m_ready));
  assign accept  = s_valid & s_ready;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses <= so every register samples pre-edge values of its peers.
    if (!resetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      op_q      <= OP_REPLACE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= s_addr;
        data_q <= s_data;
        mask_q <= s_mask;
        op_q   <= rmw_op_e'(s_op);
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_READ;
        end
        ST_READ: begin
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          m_data_q  <= ramWriteDataOut;
          m_valid_q <= 1'b1;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= accept ? ST_READ : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rmw_lane_alu #(
      .WIDTH(WRITE_STROBE_WIDTH)
    ) u_alu (
      .old_i    (ramWriteDataOut[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH]),
      .operand_i(data_q[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH]),
      .op_i     (op_q),
      .result_o (result[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH])
    );
  end

  assign ramWriteAddr = addr_q;
  assign ramWrite     = resetn & (state_q == ST_WRITE);
  assign ramWriteMask = mask_q;
  assign ramWriteData = result;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;

endmodule

// File: tb/tb_tdp_ram_rmw_ctrl.sv
// Bench for tdp_ram_rmw_ctrl: behavioural read-first RAM, directed requests, queue-based
// response scoreboard with latency tracking.
module tb_tdp_ram_rmw_ctrl;
  import rmw_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_addr;
  logic [15:0] s_data;
  logic [3:0]  s_mask;
  logic [1:0]  s_op;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_mask;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  tdp_ram_rmw_ctrl #(
    .MEM_WIDTH         (16),
    .WRITE_STROBE_WIDTH(4),
    .ADDR_WIDTH        (8)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_addr         (s_addr),
    .s_data         (s_data),
    .s_mask         (s_mask),
    .s_op           (s_op),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .ramWriteAddr   (ram_addr),
    .ramWrite       (ram_we),
    .ramWriteMask   (ram_mask),
    .ramWriteData   (ram_wdata),
    .ramWriteDataOut(ram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_count = 0;
  logic [15:0] mem [256];

  always @(posedge clk) cyc++;

  // Read-first RAM port: read data reflects contents before this edge's write.
  always @(posedge clk) begin : ram_model
    logic [15:0] w;
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      w = mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_mask[i]) w[i*4 +: 4] = ram_wdata[i*4 +: 4];
      mem[ram_addr] <= w;
      wr_count++;
    end
  end

  typedef struct {
    string       name;
    logic [15:0] data;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic mv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks accept-to-valid latency on each new response and data on each handshake.
  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
      mv_prev = 1'b0;
    end else begin
      if (m_valid && !mv_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got m_data 0x%0h with empty scoreboard", m_data);
        end else begin
          check({sb[0].name, "_latency"}, cyc - sb[0].acc, 3);
        end
      end
      if (m_valid && m_ready && sb.size() > 0) begin
        exp_t it;
        it = sb.pop_front();
        check({it.name, "_resp"}, m_data, it.data);
      end
      mv_prev = m_valid;
    end
  end

  // Called just after a posedge; returns just after the posedge at which the request was taken.
  task automatic send(input string name, input logic [7:0] a, input logic [15:0] d,
                      input logic [3:0] mk, input logic [1:0] op, input logic [15:0] exp,
                      output int acc);
    bit got = 1'b0;
    acc = -1;
    s_valid = 1'b1; s_addr = a; s_data = d; s_mask = mk; s_op = op;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (s_ready) begin
        got = 1'b1;
        acc = cyc;
        sb.push_back('{name, exp, cyc});
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got no s_ready within 50 cycles", name);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d responses still pending after 60 cycles", name, sb.size());
    end
  endtask

  task automatic mem_check(input string name, input logic [7:0] a, input logic [15:0] exp);
    check(name, mem[a], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, wc;
    bit seen;
    logic [15:0] add_exp;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;
    mem[8'h20] = 16'h8F7F;
    mem[8'h40] = 16'h5555;
    mem[8'h50] = 16'h0F0F;
    mem[8'h60] = 16'hF0F0;
    mem[8'h70] = 16'hBEEF;
    resetn = 1'b0; s_valid = 1'b0; s_addr = '0; s_data = '0; s_mask = '0; s_op = '0;
    m_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_s_ready", s_ready, 0);
    check("rst_ram_write", ram_we, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_s_ready", s_ready, 1);

    // Lanes 0 and 2 replaced: 0x1234 -> 0x1B3D.
    send("replace", 8'h10, 16'hABCD, 4'b0101, OP_REPLACE, 16'h1234, a1);
    drain("replace");
    mem_check("replace_mem", 8'h10, 16'h1B3D);

`ifdef RMW_SATURATE_EN
    add_exp = 16'h9F8F;
`else
    add_exp = 16'h9080;
`endif
    @(posedge clk); #1;
    send("add", 8'h20, 16'h1111, 4'hF, OP_ADD, 16'h8F7F, a1);
    drain("add");
    mem_check("add_mem", 8'h20, add_exp);

    @(posedge clk); #1;
    send("or", 8'h50, 16'h3030, 4'b1010, OP_OR, 16'h0F0F, a1);
    drain("or");
    mem_check("or_mem", 8'h50, 16'h3F3F);

    @(posedge clk); #1;
    send("and", 8'h60, 16'h9CA5, 4'hF, OP_AND, 16'hF0F0, a1);
    drain("and");
    mem_check("and_mem", 8'h60, 16'h90A0);

    // Zero mask: a write strobe still occurs but nothing changes.
    @(posedge clk); #1;
    wc = wr_count;
    send("mask0", 8'h10, 16'hFFFF, 4'h0, OP_REPLACE, 16'h1B3D, a1);
    drain("mask0");
    mem_check("mask0_mem", 8'h10, 16'h1B3D);
    check("mask0_wrote", wr_count - wc, 1);

    @(posedge clk); #1;
    send("b2b_first", 8'h30, 16'h0001, 4'hF, OP_ADD, 16'h0000, a1);
    send("b2b_second", 8'h30, 16'h0001, 4'hF, OP_ADD, 16'h0001, a2);
    drain("b2b");
    check("b2b_accept_gap", a2 - a1, 3);
    mem_check("b2b_mem", 8'h30, 16'h0002);

    // Response stall with m_ready low.
    @(posedge clk); #1;
    m_ready = 1'b0;
    send("stall", 8'h70, 16'h1234, 4'hF, OP_REPLACE, 16'hBEEF, a1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check("stall_valid_seen", seen, 1);
    wc = wr_count;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_m_valid", m_valid, 1);
      check("stall_m_data", m_data, 16'hBEEF);
      check("stall_s_ready", s_ready, 0);
    end
    check("stall_no_write", wr_count - wc, 0);
    m_ready = 1'b1;
    drain("stall");
    mem_check("stall_mem", 8'h70, 16'h1234);

    // Reset during WRITE drops the request.
    @(posedge clk); #1;
    s_valid = 1'b1; s_addr = 8'h40; s_data = 16'h1111; s_mask = 4'hF; s_op = OP_ADD;
    @(negedge clk);
    check("rstw_accept_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_write_before", ram_we, 1);
    resetn = 1'b0;
    #1;
    check("rstw_write_gated", ram_we, 0);
    check("rstw_ready_gated", s_ready, 0);
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    check("rstw_m_valid", m_valid, 0);
    mem_check("rstw_mem_kept", 8'h40, 16'h5555);
    @(posedge clk); #1;
    send("post_rst", 8'h40, 16'h1111, 4'hF, OP_ADD, 16'h5555, a1);
    drain("post_rst");
    mem_check("post_rst_mem", 8'h40, 16'h6666);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
